// File: rtl/sb_config_loader.sv
// sb_config_loader: streams (tile, word) pairs or a bulk clear onto a shared config bus with one-hot strobes; ports: clk/reset, start/clear/num_words control, bs_* host stream, config_data/config_en tile bus, busy/done/error/words_loaded status
module sb_config_loader #(
  parameter int NUM_TILES = 4,
  parameter int ADDR_W = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 clear,
  input  logic [CNT_W-1:0]     num_words,
  input  logic                 bs_valid,
  output logic                 bs_ready,
  input  logic [ADDR_W-1:0]    bs_addr,
  input  logic [31:0]          bs_data,
  output logic [31:0]          config_data,
  output logic [NUM_TILES-1:0] config_en,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [CNT_W-1:0]     words_loaded
);
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CLEAR, DONE, ERR} state_t;
  localparam logic [NUM_TILES-1:0] ONE = NUM_TILES'(1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_TILES - 1);
  state_t r_state;
  logic [CNT_W-1:0] r_num;
  logic [ADDR_W-1:0] r_idx;
  logic [CNT_W-1:0] w_next;
  logic w_addr_ok;
  assign w_next = words_loaded + CNT_W'(1);
  assign w_addr_ok = {1'b0, bs_addr} < (ADDR_W + 1)'(NUM_TILES);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_num <= '0;
      r_idx <= '0;
      config_data <= '0;
      config_en <= '0;
      bs_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      words_loaded <= '0;
    end else begin
      done <= 1'b0;
      config_en <= '0;
      case (r_state)
        IDLE, ERR: begin
          if (start) begin
            error <= 1'b0;
            words_loaded <= '0;
            r_state <= IDLE;
            if (num_words != '0) begin
              r_num <= num_words;
              r_state <= RECV;
              bs_ready <= 1'b1;
              busy <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end else if (clear) begin
            error <= 1'b0;
            r_idx <= '0;
            config_data <= '0;
            config_en <= ONE;
            busy <= 1'b1;
            r_state <= CLEAR;
          end
        end
        RECV: begin
          if (bs_valid) begin
            bs_ready <= 1'b0;
            if (w_addr_ok) begin
              config_data <= bs_data;
              config_en <= ONE << bs_addr;
              r_state <= WRITE;
            end else begin
              error <= 1'b1;
              busy <= 1'b0;
              r_state <= ERR;
            end
          end
        end
        WRITE: begin
          words_loaded <= w_next;
          if (w_next == r_num) begin
            done <= 1'b1;
            r_state <= DONE;
          end else begin
            bs_ready <= 1'b1;
            r_state <= RECV;
          end
        end
        CLEAR: begin
          if (r_idx == LAST) begin
            done <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
            config_en <= ONE << (r_idx + 1'b1);
          end
        end
        DONE: begin
          busy <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
